// File: rtl/pl_mem_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, FSM states and
// the byte-lane mask helper used by the store path.
package pl_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

  // Byte lanes touched by an aligned access of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/pl_dmem_bank.sv
// Word-organised data memory with per-byte write enables and an asynchronous
// (combinational) read port.
module pl_dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // NOTE: no reset on the array -- contents must survive a pipeline reset, and
  // a resettable array would also prevent mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem_q[addr][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/pl_mem_stage.sv
// MEM pipeline stage: access legality, wait-state FSM, store lane replication
// and load lane extraction/extension around a byte-enabled data memory.
module pl_mem_stage
  import pl_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mrmem,
  input  logic        mwmem,
  input  logic [1:0]  msize,
  input  logic        msigned,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  output logic [31:0] mmo,
  output logic        mstall,
  output logic        mexc
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          req, aligned, legal_req;
  logic          stall, commit, we;
  logic [31:0]   wdata, rword, shifted;
  logic [15:0]   half_v;
  logic [AW-1:0] word_idx;
  logic          unused_addr_bits;

  assign req       = mrmem | mwmem;
  assign legal_req = req & aligned;
  assign mexc      = req & ~aligned;
  assign word_idx  = malu[AW+1:2];
  assign unused_addr_bits = ^malu[31:AW+2];

  always_comb begin
    case (msize)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~malu[0];
      SZ_WORD: aligned = (malu[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (legal_req) begin
          if (WS == 4'd0) begin
            commit = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = ST_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      ST_WAIT: begin
        // A request that disappears mid-wait is abandoned without a write.
        if (!legal_req) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q < WS) begin
          stall = 1'b1;
          cnt_d = cnt_q + 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset must drop the stall and block the write without waiting for an edge.
  assign mstall = stall & ~reset;
  assign we     = commit & mwmem & ~reset;

  always_comb begin
    case (msize)
      SZ_BYTE: wdata = {4{mb[7:0]}};
      SZ_HALF: wdata = {2{mb[15:0]}};
      default: wdata = mb;
    endcase
  end

  pl_dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clk   (clock),
    .we    (we),
    .be    (lane_mask(msize, malu[1:0])),
    .addr  (word_idx),
    .wdata (wdata),
    .rdata (rword)
  );

  assign shifted = rword >> {malu[1:0], 3'b000};
  assign half_v  = malu[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    mmo = 32'd0;
    if (mrmem && aligned) begin
      case (msize)
        SZ_BYTE: mmo = {{24{msigned & shifted[7]}}, shifted[7:0]};
        SZ_HALF: mmo = {{16{msigned & half_v[15]}}, half_v};
        default: mmo = rword;
      endcase
    end
  end

endmodule

// File: tb/tb_pl_mem_stage.sv
// Scoreboard bench for pl_mem_stage: three instances (WAIT_STATES 2/3/0) are
// driven one at a time against a byte-addressed reference memory.
module tb_pl_mem_stage;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  typedef struct {
    int          inst;
    logic [31:0] mmo;
    logic        exc;
    int          stalls;
    int          id;
  } exp_t;

  logic        clock, reset;
  logic        mrmem_v [3];
  logic        mwmem_v [3];
  logic        msigned_v [3];
  logic [1:0]  msize_v [3];
  logic [31:0] malu_v [3];
  logic [31:0] mb_v [3];
  logic [31:0] mmo0, mmo1, mmo2;
  logic        mstall0, mstall1, mstall2, mexc0, mexc1, mexc2;
  logic [31:0] mmo_s [3];
  logic        mstall_s [3];
  logic        mexc_s [3];

  assign mmo_s[0] = mmo0;  assign mstall_s[0] = mstall0;  assign mexc_s[0] = mexc0;
  assign mmo_s[1] = mmo1;  assign mstall_s[1] = mstall1;  assign mexc_s[1] = mexc1;
  assign mmo_s[2] = mmo2;  assign mstall_s[2] = mstall2;  assign mexc_s[2] = mexc2;

  pl_mem_stage #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u0 (
    .clock(clock), .reset(reset), .mrmem(mrmem_v[0]), .mwmem(mwmem_v[0]),
    .msize(msize_v[0]), .msigned(msigned_v[0]), .malu(malu_v[0]), .mb(mb_v[0]),
    .mmo(mmo0), .mstall(mstall0), .mexc(mexc0));
  pl_mem_stage #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u1 (
    .clock(clock), .reset(reset), .mrmem(mrmem_v[1]), .mwmem(mwmem_v[1]),
    .msize(msize_v[1]), .msigned(msigned_v[1]), .malu(malu_v[1]), .mb(mb_v[1]),
    .mmo(mmo1), .mstall(mstall1), .mexc(mexc1));
  pl_mem_stage #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u2 (
    .clock(clock), .reset(reset), .mrmem(mrmem_v[2]), .mwmem(mwmem_v[2]),
    .msize(msize_v[2]), .msigned(msigned_v[2]), .malu(malu_v[2]), .mb(mb_v[2]),
    .mmo(mmo2), .mstall(mstall2), .mexc(mexc2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_err    = 0;
  int          next_id  = 0;
  exp_t        sb_q [$];
  exp_t        mon_e;
  int          scnt [3];
  logic [7:0]  mem_m [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 0;
  endfunction

  function automatic int dep_of(input int i);
    return (i == 1) ? 64 : 1024;
  endfunction

  function automatic int key(input int i, input logic [31:0] a);
    return i * 65536 + int'(a & 32'(dep_of(i) * 4 - 1));
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == B) ? 1 : (sz == H) ? 2 : 4;
  endfunction

  function automatic logic illegal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == R) || (sz == H && a[0]) || (sz == W && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_load(input int i, input logic [31:0] a,
                                         input logic [1:0] sz, input logic sg);
    int          n = nbytes(sz);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++) v |= 32'(mem_m[key(i, a + 32'(k))]) << (8 * k);
    if (sg && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic m_store(input int i, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] d);
    for (int k = 0; k < nbytes(sz); k++) mem_m[key(i, a + 32'(k))] = 8'(d >> (8 * k));
  endtask

  task automatic drive(input int i, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d);
    mrmem_v[i] = rd;  mwmem_v[i] = wr;  msize_v[i] = sz;
    msigned_v[i] = sg;  malu_v[i] = a;  mb_v[i] = d;
  endtask

  task automatic idle(input int i);
    mrmem_v[i] = 1'b0;
    mwmem_v[i] = 1'b0;
  endtask

  // Issue one access, queue its expected outcome, and hold it until the DUT
  // releases the stall; returns just after the commit edge with inputs still set.
  task automatic access(input int i, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic exc = illegal(sz, a);
    e.inst   = i;
    e.exc    = exc;
    e.mmo    = (rd && !exc) ? m_load(i, a, sz, sg) : 32'd0;
    e.stalls = exc ? 0 : ws_of(i);
    e.id     = next_id++;
    sb_q.push_back(e);
    if (wr && !exc) m_store(i, a, sz, d);
    drive(i, rd, wr, sz, sg, a, d);
    for (int c = 0; ; c++) begin
      @(negedge clock);
      if (!mstall_s[i]) break;
      if (c >= 40) begin
        check("stall_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset || !(mrmem_v[i] || mwmem_v[i])) begin
        scnt[i] = 0;
      end else if (mstall_s[i]) begin
        scnt[i]++;
      end else begin
        if (sb_q.size() == 0) begin
          check("unexpected_completion", 32'(i), 32'hFFFF_FFFF);
        end else begin
          mon_e = sb_q.pop_front();
          check($sformatf("inst#%0d", mon_e.id), 32'(i), 32'(mon_e.inst));
          check($sformatf("mmo#%0d", mon_e.id), mmo_s[i], mon_e.mmo);
          check($sformatf("mexc#%0d", mon_e.id), 32'(mexc_s[i]), 32'(mon_e.exc));
          check($sformatf("stalls#%0d", mon_e.id), 32'(scnt[i]), 32'(mon_e.stalls));
        end
        scnt[i] = 0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          op;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, W, 1'b0, 32'd0, 32'd0);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check("rst_mstall", 32'(mstall_s[i]), 32'd0);
      check("rst_mexc", 32'(mexc_s[i]), 32'd0);
      check("rst_mmo", mmo_s[i], 32'd0);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // Word store then load with two wait states; sub-word overwrite.
    access(0, 1'b0, 1'b1, W, 1'b0, 32'h40, 32'h1234_5678);
    access(0, 1'b1, 1'b0, W, 1'b0, 32'h40, 32'd0);
    access(0, 1'b0, 1'b1, B, 1'b0, 32'h41, 32'h0000_00AA);
    access(0, 1'b1, 1'b0, W, 1'b0, 32'h40, 32'd0);

    // Misaligned and reserved-size requests must not stall or write.
    access(0, 1'b1, 1'b0, W, 1'b0, 32'h42, 32'd0);
    access(0, 1'b0, 1'b1, H, 1'b0, 32'h43, 32'hFFFF_FFFF);
    access(0, 1'b0, 1'b1, R, 1'b0, 32'h40, 32'hFFFF_FFFF);
    access(0, 1'b1, 1'b0, W, 1'b0, 32'h40, 32'd0);

    // Simultaneous load+store returns the pre-write word.
    access(0, 1'b1, 1'b1, W, 1'b0, 32'h44, 32'h0BAD_F00D);
    access(0, 1'b1, 1'b1, H, 1'b1, 32'h46, 32'h0000_9999);
    access(0, 1'b1, 1'b0, W, 1'b0, 32'h44, 32'd0);
    idle(0);

    // Store dropped one cycle into its wait: no write, stall falls at once.
    @(posedge clock);
    #1 drive(0, 1'b0, 1'b1, W, 1'b0, 32'h40, 32'h5555_5555);
    @(negedge clock);
    check("abort_stall_hi", 32'(mstall_s[0]), 32'd1);
    @(posedge clock);
    #1 idle(0);
    #1 check("abort_stall_lo", 32'(mstall_s[0]), 32'd0);
    @(posedge clock);
    #1 access(0, 1'b1, 1'b0, W, 1'b0, 32'h40, 32'd0);

    // Sign/zero extension of sub-word loads.
    access(0, 1'b0, 1'b1, W, 1'b0, 32'h80, 32'h80FF_7F01);
    access(0, 1'b1, 1'b0, B, 1'b1, 32'h82, 32'd0);
    access(0, 1'b1, 1'b0, B, 1'b0, 32'h83, 32'd0);
    access(0, 1'b1, 1'b0, H, 1'b1, 32'h80, 32'd0);
    access(0, 1'b1, 1'b0, H, 1'b0, 32'h82, 32'd0);
    access(0, 1'b1, 1'b0, H, 1'b1, 32'h82, 32'd0);
    idle(0);

    // Zero wait states with address wrap.
    access(2, 1'b0, 1'b1, W, 1'b0, 32'h1000, 32'hDEAD_BEEF);
    access(2, 1'b1, 1'b0, W, 1'b0, 32'h0, 32'd0);
    idle(2);

    // Reset one cycle into a three-wait-state store: aborted, old data kept.
    access(1, 1'b0, 1'b1, W, 1'b0, 32'h10, 32'hCAFE_F00D);
    idle(1);
    @(posedge clock);
    #1 drive(1, 1'b0, 1'b1, W, 1'b0, 32'h10, 32'h1111_1111);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check("rst_mid_stall", 32'(mstall_s[1]), 32'd0);
    idle(1);
    @(posedge clock);
    #1 reset = 1'b0;
    access(1, 1'b1, 1'b0, W, 1'b0, 32'h10, 32'd0);
    idle(1);
    access(0, 1'b1, 1'b0, W, 1'b0, 32'h40, 32'd0);
    idle(0);

    // Randomised mix on the two 1024-word instances; upper address bits vary.
    for (int i = 0; i < 3; i += 2) begin
      for (int w = 0; w < 16; w++) access(i, 1'b0, 1'b1, W, 1'b0, 32'h100 + 32'(4 * w), $urandom);
      for (int n = 0; n < 150; n++) begin
        op = int'($urandom_range(0, 2));
        sz = 2'($urandom_range(0, 3));
        a  = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
        if ($urandom_range(0, 3) != 0) a &= (sz == H) ? ~32'd1 : (sz == W) ? ~32'd3 : ~32'd0;
        access(i, op != 1, op != 0, sz, 1'($urandom), a, $urandom);
        if ($urandom_range(0, 3) == 0) begin
          idle(i);
          @(posedge clock);
          #1;
        end
      end
      idle(i);
    end

    repeat (3) @(posedge clock);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
